// File: rtl/fpu_ss_issue_buffer_if.sv
// Handshake bundle for the FPU subsystem issue buffer. It groups the push,
// commit and dispatch signals. Signal names are written from the buffer's
// point of view.
interface fpu_ss_issue_buffer_if #(
    parameter int unsigned NUM_RS    = 3,
    parameter int unsigned RFR_WIDTH = 32,
    parameter int unsigned ID_WIDTH  = 4
) ();
    // Push side
    logic                          in_valid_i;
    logic                          in_ready_o;
    logic [31:0]                   in_instr_i;
    logic [NUM_RS*RFR_WIDTH-1:0]   in_rs_i;
    logic [ID_WIDTH-1:0]           in_id_i;
    logic [1:0]                    in_mode_i;

    // Commit side
    logic                          commit_valid_i;
    logic [ID_WIDTH-1:0]           commit_id_i;
    logic                          commit_kill_i;

    // Dispatch side
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic [31:0]                   out_instr_o;
    logic [NUM_RS*RFR_WIDTH-1:0]   out_rs_o;
    logic [ID_WIDTH-1:0]           out_id_o;
    logic [1:0]                    out_mode_o;

    // Buffer side
    modport slave (
        input  in_valid_i, in_instr_i, in_rs_i, in_id_i, in_mode_i,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o, out_instr_o, out_rs_o, out_id_o, out_mode_o
    );

    // Core / dispatcher side
    modport master (
        output in_valid_i, in_instr_i, in_rs_i, in_id_i, in_mode_i,
        output commit_valid_i, commit_id_i, commit_kill_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o, out_instr_o, out_rs_o, out_id_o, out_mode_o
    );
endinterface

// File: rtl/fpu_ss_issue_buffer.sv
// Issue buffer for offloaded FPU instructions. Instructions are held in a
// circular buffer until the core commits them. Each one then leaves in push
// order. A killed head entry is dropped silently, one entry per cycle.
module fpu_ss_issue_buffer #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned NUM_RS    = 3,
    parameter int unsigned RFR_WIDTH = 32,
    parameter int unsigned ID_WIDTH  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    fpu_ss_issue_buffer_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam int unsigned RS_W  = NUM_RS * RFR_WIDTH;

    // Payload storage
    logic [31:0]         instr_q [DEPTH];
    logic [RS_W-1:0]     rs_q    [DEPTH];
    logic [ID_WIDTH-1:0] id_q    [DEPTH];
    logic [1:0]          mode_q  [DEPTH];

    // Per-entry flags
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [DEPTH-1:0]    committed_q, committed_d;
    logic [DEPTH-1:0]    killed_q, killed_d;

    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                in_ready_s;
    logic                out_valid_s;
    logic                push_s;
    logic                pop_s;
    logic                drop_s;
    logic                release_s;
    logic                push_commit_s;
    logic [DEPTH-1:0]    commit_hit_s;

    // Handshake qualification. A pop does not free space in its own cycle.
    always_comb begin
        in_ready_s    = (count_q < CNT_W'(DEPTH)) && !flush_i;
        out_valid_s   = valid_q[head_q] & committed_q[head_q] & ~killed_q[head_q];
        drop_s        = valid_q[head_q] & killed_q[head_q];
        push_s        = bus.in_valid_i & in_ready_s;
        pop_s         = out_valid_s & bus.out_ready_i;
        release_s     = pop_s | drop_s;
        push_commit_s = push_s & bus.commit_valid_i & (bus.commit_id_i == bus.in_id_i);
    end

    // Match the commit id against every stored valid entry
    always_comb begin
        commit_hit_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.commit_valid_i && valid_q[i] && (id_q[i] == bus.commit_id_i)) begin
                commit_hit_s[i] = 1'b1;
            end else begin
                commit_hit_s[i] = 1'b0;
            end
        end
    end

    // Next-state logic for flags, pointers and occupancy. Flush has top priority.
    always_comb begin
        valid_d     = valid_q;
        committed_d = committed_q;
        killed_d    = killed_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        if (flush_i) begin
            valid_d     = '0;
            committed_d = '0;
            killed_d    = '0;
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_hit_s[i]) begin
                    committed_d[i] = 1'b1;
                    killed_d[i]    = killed_q[i] | bus.commit_kill_i;
                end else begin
                    committed_d[i] = committed_q[i];
                    killed_d[i]    = killed_q[i];
                end
            end
            if (release_s) begin
                valid_d[head_q]     = 1'b0;
                committed_d[head_q] = 1'b0;
                killed_d[head_q]    = 1'b0;
                head_d              = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            // The tail slot is never valid while a push is accepted, so this
            // write cannot collide with the head release or a stored commit.
            if (push_s) begin
                valid_d[tail_q]     = 1'b1;
                committed_d[tail_q] = push_commit_s;
                killed_d[tail_q]    = push_commit_s & bus.commit_kill_i;
                tail_d              = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            case ({push_s, release_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Flag, pointer and occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q     <= '0;
            committed_q <= '0;
            killed_q    <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            committed_q <= committed_d;
            killed_q    <= killed_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    // Payload write at the tail. Storage is cleared on reset, so the dispatch
    // payload reads as zero while in reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                rs_q[i]    <= '0;
                id_q[i]    <= '0;
                mode_q[i]  <= '0;
            end
        end else if (push_s) begin
            instr_q[tail_q] <= bus.in_instr_i;
            rs_q[tail_q]    <= bus.in_rs_i;
            id_q[tail_q]    <= bus.in_id_i;
            mode_q[tail_q]  <= bus.in_mode_i;
        end
    end

    // The dispatch outputs come only from registered state. in_ready also
    // depends on flush_i.
    assign bus.in_ready_o  = in_ready_s;
    assign bus.out_valid_o = out_valid_s;
    assign bus.out_instr_o = instr_q[head_q];
    assign bus.out_rs_o    = rs_q[head_q];
    assign bus.out_id_o    = id_q[head_q];
    assign bus.out_mode_o  = mode_q[head_q];
    assign count_o         = count_q;

endmodule

// File: doc/fpu_ss_issue_buffer.md
FPU_SS_ISSUE_BUFFER -- requirements
Module: fpu_ss_issue_buffer

Interface
REQ-001: Parameter DEPTH, default 4, SHALL be the number of buffered offloaded instructions; legal values are powers of two, 2..16.
REQ-002: Parameter NUM_RS, default 3, SHALL be the number of source operands per instruction.
REQ-003: Parameter RFR_WIDTH, default 32, SHALL be the width of each source operand.
REQ-004: Parameter ID_WIDTH, default 4, SHALL be the width of the instruction id.
REQ-005: clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006: rst_ni  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-007: in_valid_i / in_ready_o  in/out  1/1  SHALL form the push handshake.
REQ-008: in_instr_i  in  32  SHALL carry the instruction word.
REQ-009: in_rs_i  in  NUM_RS*RFR_WIDTH  SHALL carry the operands; rs[0] is in the LSBs.
REQ-010: in_id_i  in  ID_WIDTH  SHALL carry the id; in_mode_i  in  2  SHALL carry the privilege mode.
REQ-011: commit_valid_i  in  1, commit_id_i  in  ID_WIDTH, commit_kill_i  in  1  SHALL form the commit interface.
REQ-012: out_valid_o / out_ready_i  out/in  1/1  SHALL form the dispatch handshake.
REQ-013: out_instr_o, out_rs_o, out_id_o and out_mode_o SHALL have the widths of their in_* counterparts.
REQ-014: flush_i  in  1  SHALL synchronously discard all entries.
REQ-015: count_o  out  $clog2(DEPTH+1)  SHALL report occupied entries, killed entries included.

Function
REQ-016: Storage SHALL be a circular buffer with head and tail pointers; each entry holds a payload plus valid, committed and killed flags.
REQ-017: in_ready_o SHALL be (count_o < DEPTH) && !flush_i; a same-cycle pop SHALL NOT free space for a push, so there is no full-bypass.
REQ-018: A push SHALL occur when in_valid_i && in_ready_o; the entry is written at tail with committed=0 and killed=0, and tail advances, wrapping DEPTH-1 -> 0.
REQ-019: On commit_valid_i, the valid entry whose id equals commit_id_i SHALL set committed=1; if commit_kill_i=1 it SHALL also set killed=1.
REQ-020: A commit whose id matches the entry being pushed in the same cycle SHALL apply to that entry.
REQ-021: A commit matching no entry, pushed or stored, SHALL be ignored; ids in flight are unique by protocol.
REQ-022: out_valid_o SHALL be head.valid && head.committed && !head.killed, driven from flops only, with no combinational path from any input.
REQ-023: The out_* payload SHALL show the head entry whenever out_valid_o=1, and SHALL hold stable while out_valid_o && !out_ready_i.
REQ-024: A pop SHALL occur when out_valid_o && out_ready_i; head advances with wrap.
REQ-025: A head entry with killed=1 SHALL be dropped automatically in one cycle, with no out_valid_o, at one entry per cycle.
REQ-026: Minimum latency SHALL be one cycle: with a push and its non-kill commit in cycle N, out_valid_o=1 in cycle N+1.
REQ-027: Entries SHALL dispatch strictly in push order; an uncommitted head blocks younger committed entries.
REQ-028: Simultaneous push and pop SHALL leave count_o unchanged.
REQ-029: flush_i SHALL clear all valid flags and reset both pointers and count_o to 0 on the next edge, overriding a same-cycle push, pop or commit.

Reset
REQ-030: While rst_ni=0: pointers=0, count_o=0, all flags=0, out_valid_o=0 and in_ready_o=1; payload outputs SHALL be 0.
REQ-031: Reset asserted mid-operation SHALL discard all entries immediately, with no dispatch in the cycle after release.

Verification
REQ-032: Push id 3, commit id 3 kill=0 in the same cycle, out_ready_i=1 -> out_valid_o=1 with out_id_o=3 in the next cycle, and count_o returns to 0 after the pop.
REQ-033: Push ids 0..3 (DEPTH=4) with no commits -> in_ready_o=0 and count_o=4; commit id 2 -> out_valid_o stays 0 because head id 0 is uncommitted.
REQ-034: Fill ids 0..3, commit id 0 kill=1 and ids 1..3 kill=0 -> id 0 is dropped silently and dispatch order is 1,2,3.
REQ-035: Wrap test: 20 push/commit/pop sequences at DEPTH=4, out_ready_i toggled randomly -> payload order and values match, and payload is stable during stalls.
REQ-036: Full buffer with out_ready_i=1 and in_valid_i=1 -> no push that cycle; count_o goes 4 -> 3, then the push is accepted.
REQ-037: Two entries pending, then flush_i=1 together with a push and a commit -> count_o=0 and out_valid_o=0 on the next cycle; repeat the sequence with rst_ni pulsed low instead -> same result.
